lfsr_bcd_gen: RTL

LFSR_BCD_GEN -- requirements
Module: lfsr_bcd_gen

---
 rtl/lfsr_bcd_gen_if.sv | 22 ++
 rtl/lfsr_bcd_gen.sv | 121 ++++++++++++
 2 files changed

// File: rtl/lfsr_bcd_gen_if.sv
// Control/status bundle for lfsr_bcd_gen: mode/step/seed in, LFSR state and BCD view out.
interface lfsr_bcd_gen_if #(
    parameter int unsigned WIDTH = 7
);
    logic [1:0]       mode;
    logic             step;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] value;
    logic [19:0]      bcd;
    logic             bcd_valid;
    logic             wrap;

    modport master (
        output mode, step, seed,
        input  value, bcd, bcd_valid, wrap
    );

    modport slave (
        input  mode, step, seed,
        output value, bcd, bcd_valid, wrap
    );
endinterface

// File: rtl/lfsr_bcd_gen.sv
// Fibonacci-style LFSR with hold/step/run/load modes and a sequential
// double-dabble converter presenting the current state as five BCD digits.
module lfsr_bcd_gen #(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = 7'h60,
    parameter int unsigned      DIV   = 50_000_000
) (
    input logic          clk,
    input logic          rst_n,
    lfsr_bcd_gen_if.slave bus
);

    localparam int unsigned PW = $clog2(DIV);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] seed_reg, seed_d;
    logic [PW-1:0]    pre_q;
    logic             pre_hit;
    logic             adv;
    logic             wrap_q;
    logic             chg_q;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_q;
    logic [19:0]      acc_q, acc_adj;
    logic [4:0]       it_q;
    logic [19:0]      bcd_q;
    logic             bcd_valid_q;

    assign pre_hit = (pre_q == PW'(DIV - 1));

    always_comb begin
        value_d = value_q;
        seed_d  = seed_reg;
        adv     = 1'b0;
        case (bus.mode)
            MODE_STEP: adv = bus.step;
            MODE_RUN:  adv = pre_hit;
            MODE_LOAD: begin
                // Zero seed is replaced by 1 so the lockup state is unreachable
                value_d = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
                seed_d  = value_d;
            end
            default: ;
        endcase
        if (adv)
            value_d = {value_q[WIDTH-2:0], ^(value_q & TAPS)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= WIDTH'(1);
            seed_reg <= WIDTH'(1);
            pre_q    <= '0;
            wrap_q   <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            value_q  <= value_d;
            seed_reg <= seed_d;
            pre_q    <= (bus.mode == MODE_RUN && !pre_hit) ? pre_q + PW'(1) : '0;
            wrap_q   <= adv && (value_d == seed_reg);
            chg_q    <= (value_d != value_q);
        end
    end

    always_comb begin
        acc_adj = acc_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    // chg_q lags the value update by one cycle; any change restarts from scratch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sh_q        <= '0;
            acc_q       <= '0;
            it_q        <= '0;
            bcd_q       <= 20'h00001;
            bcd_valid_q <= 1'b1;
        end else if (chg_q) begin
            sh_q        <= value_q;
            acc_q       <= '0;
            it_q        <= '0;
            state       <= S_SHIFT;
            bcd_valid_q <= 1'b0;
        end else begin
            case (state)
                S_SHIFT: begin
                    {acc_q, sh_q} <= {acc_adj, sh_q} << 1;
                    it_q          <= it_q + 5'd1;
                    if (it_q == 5'(WIDTH - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    bcd_q       <= acc_q;
                    bcd_valid_q <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.value     = value_q;
    assign bus.bcd       = bcd_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.wrap      = wrap_q;

endmodule
